// File: rtl/fft_ram_reader.sv
// rtl/fft_ram_reader.sv - read sequencer that sweeps the FFT RAM and streams words through a credit-controlled skid FIFO
module fft_ram_reader #(
  parameter int DWL         = 16,
  parameter int AWL         = 8,
  parameter int RD_LATENCY  = 1,
  parameter int BIT_REVERSE = 0,
  parameter int FIFO_DEPTH  = RD_LATENCY + 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_START,
  input  logic [AWL-1:0] i_LAST_ADDR,
  output logic           o_BUSY,
  output logic           o_DONE,
  output logic           o_RAM_EN,
  output logic           o_RAM_WrE,
  output logic [AWL-1:0] o_RAM_ADDR,
  input  logic [DWL-1:0] i_RAM_DATA,
  output logic [DWL-1:0] o_DATA,
  output logic           o_VALID,
  input  logic           i_READY,
  output logic           o_LAST
);

  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [AWL-1:0]        last_addr, cnt, issue_idx, issue_rev, issue_addr;
  logic                  issue, issue_last, issued_all, ram_last;
  logic [RD_LATENCY-1:0] pipe_vld, pipe_lst;
  logic [DWL-1:0]        fifo_data [FIFO_DEPTH];
  logic                  fifo_lst  [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         fifo_cnt, inflight, occ_after_pop;
  logic                  push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_RAM_WrE = 1'b0;
  assign o_BUSY    = (state == S_READ) || (state == S_DRAIN);
  assign o_DONE    = (state == S_DONE);
  assign o_VALID   = (fifo_cnt != '0);
  assign o_DATA    = fifo_data[rd_ptr];
  assign o_LAST    = o_VALID & fifo_lst[rd_ptr];
  assign pop       = o_VALID & i_READY;
  assign push      = pipe_vld[RD_LATENCY-1];

  // Credit: every issued read owns a FIFO slot from the moment o_RAM_EN rises
  always_comb begin
    inflight = CW'(o_RAM_EN);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_vld[i]);
    end
    occ_after_pop = fifo_cnt + inflight - CW'(pop);
  end

  always_comb begin
    for (int j = 0; j < AWL; j++) begin
      issue_rev[j] = issue_idx[AWL-1-j];
    end
    issue_addr = (BIT_REVERSE != 0) ? issue_rev : issue_idx;
  end

  // The first read leaves on the start edge so o_RAM_EN rises the cycle after i_START
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_idx  = cnt;
    issue_last = (cnt == last_addr);
    case (state)
      S_IDLE: begin
        issue_idx  = '0;
        issue_last = (i_LAST_ADDR == '0);
        if (i_START) begin
          state_nxt = S_READ;
          issue     = 1'b1;
        end
      end
      S_READ: begin
        if (issued_all) state_nxt = S_DRAIN;
        else if (occ_after_pop < DEPTH_C) issue = 1'b1;
      end
      S_DRAIN: if (pop && o_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      last_addr  <= '0;
      cnt        <= '0;
      issued_all <= 1'b0;
      o_RAM_EN   <= 1'b0;
      o_RAM_ADDR <= '0;
      ram_last   <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_RAM_EN <= issue;
      ram_last <= issue & issue_last;
      if (issue) begin
        o_RAM_ADDR <= issue_addr;
        if (!issue_last) cnt <= issue_idx + 1'b1;
      end
      if (state == S_IDLE) begin
        issued_all <= issue & issue_last;
        if (i_START) last_addr <= i_LAST_ADDR;
      end else if (issue && issue_last) begin
        issued_all <= 1'b1;
      end
    end
  end

  // Capture follows the flag pipe, never data changes on the RAM output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_vld <= '0;
      pipe_lst <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_lst[i]  <= 1'b0;
      end
    end else begin
      pipe_vld[0] <= o_RAM_EN;
      pipe_lst[0] <= ram_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_lst[i] <= pipe_lst[i-1];
      end
      if (push) begin
        fifo_data[wr_ptr] <= i_RAM_DATA;
        fifo_lst[wr_ptr]  <= pipe_lst[RD_LATENCY-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fft_ram_reader.sv
// tb/tb_fft_ram_reader.sv - self-checking bench for fft_ram_reader across latency and bit-reverse configurations
module tb_fft_ram_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  last_in = '0;
  int          sel = 0;
  int          errs = 0;
  int          checks = 0;

  logic [2:0]  start_v, ready_v;
  logic        busy [3];
  logic        done [3];
  logic        en   [3];
  logic        wre  [3];
  logic        valid[3];
  logic        lst  [3];
  logic [15:0] data [3];
  logic [7:0]  addr_ab [2];
  logic [2:0]  addr_c;
  logic [15:0] ram [256];
  logic [15:0] q1 [3];
  logic [15:0] q2 [3];
  logic [15:0] rd0, rd1, rd2;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = start && (sel == i);
      ready_v[i] = ready && (sel == i);
    end
  end

  // RAM model: first register always follows the address, optional second output register
  always_ff @(posedge clk) begin
    q1[0] <= ram[addr_ab[0]];
    q1[1] <= ram[addr_ab[1]];
    q1[2] <= ram[{5'b0, addr_c}];
    for (int i = 0; i < 3; i++) q2[i] <= q1[i];
  end
  assign rd0 = q1[0];
  assign rd1 = q2[1];
  assign rd2 = q2[2];

  fft_ram_reader #(.DWL(16), .AWL(8), .RD_LATENCY(1), .BIT_REVERSE(0)) u_a (
    .CLK(clk), .RST(rst), .i_START(start_v[0]), .i_LAST_ADDR(last_in),
    .o_BUSY(busy[0]), .o_DONE(done[0]), .o_RAM_EN(en[0]), .o_RAM_WrE(wre[0]),
    .o_RAM_ADDR(addr_ab[0]), .i_RAM_DATA(rd0), .o_DATA(data[0]), .o_VALID(valid[0]),
    .i_READY(ready_v[0]), .o_LAST(lst[0]));

  fft_ram_reader #(.DWL(16), .AWL(8), .RD_LATENCY(2), .BIT_REVERSE(0)) u_b (
    .CLK(clk), .RST(rst), .i_START(start_v[1]), .i_LAST_ADDR(last_in),
    .o_BUSY(busy[1]), .o_DONE(done[1]), .o_RAM_EN(en[1]), .o_RAM_WrE(wre[1]),
    .o_RAM_ADDR(addr_ab[1]), .i_RAM_DATA(rd1), .o_DATA(data[1]), .o_VALID(valid[1]),
    .i_READY(ready_v[1]), .o_LAST(lst[1]));

  fft_ram_reader #(.DWL(16), .AWL(3), .RD_LATENCY(2), .BIT_REVERSE(1)) u_c (
    .CLK(clk), .RST(rst), .i_START(start_v[2]), .i_LAST_ADDR(last_in[2:0]),
    .o_BUSY(busy[2]), .o_DONE(done[2]), .o_RAM_EN(en[2]), .o_RAM_WrE(wre[2]),
    .o_RAM_ADDR(addr_c), .i_RAM_DATA(rd2), .o_DATA(data[2]), .o_VALID(valid[2]),
    .i_READY(ready_v[2]), .o_LAST(lst[2]));

  function automatic int rl(input int s);     return (s == 0) ? 1 : 2; endfunction
  function automatic int awl(input int s);    return (s == 2) ? 3 : 8; endfunction
  function automatic int cur_addr(input int s);
    return (s == 2) ? int'(addr_c) : int'(addr_ab[s]);
  endfunction
  function automatic int rev(input int k, input int w);
    int r = 0;
    for (int j = 0; j < w; j++) if (k[j]) r |= (1 << (w - 1 - j));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input int s, input string tag);
    chk({tag, "_busy"},  busy[s], 0);
    chk({tag, "_done"},  done[s], 0);
    chk({tag, "_en"},    en[s], 0);
    chk({tag, "_valid"}, valid[s], 0);
    chk({tag, "_last"},  lst[s], 0);
    chk({tag, "_data"},  data[s], 0);
    chk({tag, "_addr"},  cur_addr(s), 0);
  endtask

  // Drive one sweep on instance sel; rmode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  task automatic run_sweep(input int last, input int rmode, input bit poke,
                           output int first_v, output int done_c);
    int order[$];
    int issued = 0, popped = 0, c = 0, busy_cnt = 0, dones = 0;
    bit prev_stall = 0;
    logic [15:0] prev_d = '0;
    logic prev_l = 0;
    first_v = -1;
    done_c  = -1;
    for (int k = 0; k <= last; k++) order.push_back((sel == 2) ? rev(k, awl(sel)) : k);
    @(negedge clk);
    last_in = 8'(last);
    start   = 1'b1;
    ready   = 1'b0;
    while (dones == 0 && c < 4000) begin
      @(negedge clk);
      c++;
      start = poke && (c == 2);
      if (poke && c == 2) last_in = 8'($urandom_range(0, 255));
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      chk("ram_wre", wre[sel], 0);
      if (en[sel]) begin
        if (issued <= last) chk("ram_addr", cur_addr(sel), order[issued]);
        else chk("extra_issue", issued, last);
        issued++;
      end
      chk("occupancy_le_depth", (issued - popped) <= rl(sel) + 2, 1);
      if (prev_stall) begin
        chk("stall_valid", valid[sel], 1);
        chk("stall_data", data[sel], prev_d);
        chk("stall_last", lst[sel], prev_l);
      end
      if (valid[sel] && ready) begin
        if (popped <= last) begin
          chk("word_data", data[sel], ram[order[popped]]);
          chk("word_last", lst[sel], popped == last);
        end else chk("extra_word", popped, last);
        if (first_v < 0) first_v = c;
        popped++;
      end
      prev_stall = valid[sel] && !ready;
      prev_d = data[sel];
      prev_l = lst[sel];
      if (busy[sel]) busy_cnt++;
      if (done[sel]) begin
        dones++;
        done_c = c;
        chk("busy_low_in_done", busy[sel], 0);
      end
    end
    chk("done_seen", dones, 1);
    chk("word_count", popped, last + 1);
    chk("issue_count", issued, last + 1);
    chk("busy_cycles", busy_cnt, done_c - 1);
    ready = 1'b0;
    @(negedge clk);
    chk("done_single_pulse", done[sel], 0);
    chk("busy_after_done", busy[sel], 0);
  endtask

  initial begin
    int fv, dc, n;
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    #1 rst = 1'b1;
    #2;
    for (int s = 0; s < 3; s++) outputs_zero(s, "reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    sel = 0; run_sweep(7, 0, 0, fv, dc);
    chk("rl1_first_valid", fv, 3);
    chk("rl1_done_cycle", dc, 11);
    sel = 1; run_sweep(7, 0, 0, fv, dc);
    chk("rl2_first_valid", fv, 4);
    chk("rl2_done_cycle", dc, 12);
    sel = 2; run_sweep(7, 0, 0, fv, dc);
    chk("brev_done_cycle", dc, 12);
    sel = 1; run_sweep(15, 1, 0, fv, dc);
    sel = 0; run_sweep(0, 0, 1, fv, dc);
    chk("single_rl1_done", dc, 4);
    sel = 1; run_sweep(0, 0, 1, fv, dc);
    chk("single_rl2_done", dc, 5);

    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int it = 0; it < 9; it++) begin
      sel = it % 3;
      n = (sel == 2) ? $urandom_range(0, 7) : $urandom_range(0, 40);
      run_sweep(n, 2, it[0], fv, dc);
    end
    sel = 0; run_sweep(255, 2, 0, fv, dc);
    sel = 1; run_sweep(255, 0, 0, fv, dc);
    chk("wrap_done_cycle", dc, 260);

    // Abort a 16-word sweep while word 5 is on the stream
    sel = 1;
    @(negedge clk);
    last_in = 8'd15;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
    end
    chk("abort_word5_data", data[1], ram[5]);
    #2 rst = 1'b1;
    #1 outputs_zero(1, "abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_abort_valid", valid[1], 0);
      chk("post_abort_done", done[1], 0);
      chk("post_abort_en", en[1], 0);
    end
    run_sweep(3, 0, 0, fv, dc);
    chk("restart_done_cycle", dc, 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
